// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults, depth helper and request encoding
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEPTH = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic int depth_of(input int addr_width);
        return 2 ** addr_width;
    endfunction

    // Encoding matches the {wr, rd} bit pair so a plain cast selects the case.
    typedef enum logic [1:0] {
        REQ_NOP = 2'b00,
        REQ_RD  = 2'b01,
        REQ_WR  = 2'b10,
        REQ_RW  = 2'b11
    } req_e;

endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FWFT FIFO pointer/flag controller; optional level port under FIFO_CTRL_LEVEL_EN
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    req_e                  req;
    logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt, r_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_inc, r_inc;
    logic                  full_reg, empty_reg;
    logic                  full_nxt, empty_nxt;
    logic                  overflow_nxt, underflow_nxt;

    assign req   = req_e'({wr, rd});
    assign w_inc = w_ptr + PTR_ONE;
    assign r_inc = r_ptr + PTR_ONE;

    assign wr_en  = wr & (~full_reg | rd);
    assign w_addr = w_ptr;
    assign r_addr = r_ptr;
    assign full   = full_reg;
    assign empty  = empty_reg;

    always_comb begin
        w_ptr_nxt     = w_ptr;
        r_ptr_nxt     = r_ptr;
        full_nxt      = full_reg;
        empty_nxt     = empty_reg;
        overflow_nxt  = 1'b0;
        underflow_nxt = 1'b0;
        case (req)
            REQ_WR: begin
                if (!full_reg) begin
                    w_ptr_nxt = w_inc;
                    empty_nxt = 1'b0;
                    full_nxt  = (w_inc == r_ptr);
                end else begin
                    overflow_nxt = 1'b1;
                end
            end
            REQ_RD: begin
                if (!empty_reg) begin
                    r_ptr_nxt = r_inc;
                    full_nxt  = 1'b0;
                    empty_nxt = (r_inc == w_ptr);
                end else begin
                    underflow_nxt = 1'b1;
                end
            end
            REQ_RW: begin
                // Empty: nothing to pop, so this degenerates to a plain write.
                if (empty_reg) begin
                    w_ptr_nxt = w_inc;
                    empty_nxt = 1'b0;
                    full_nxt  = (w_inc == r_ptr);
                end else begin
                    w_ptr_nxt = w_inc;
                    r_ptr_nxt = r_inc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            w_ptr     <= w_ptr_nxt;
            r_ptr     <= r_ptr_nxt;
            full_reg  <= full_nxt;
            empty_reg <= empty_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

`ifdef FIFO_CTRL_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] level_reg, level_nxt;

    always_comb begin
        level_nxt = level_reg;
        case (req)
            REQ_WR:  if (!full_reg)  level_nxt = level_reg + LVL_ONE;
            REQ_RD:  if (!empty_reg) level_nxt = level_reg - LVL_ONE;
            REQ_RW:  if (empty_reg)  level_nxt = level_reg + LVL_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_reg <= '0;
        else       level_reg <= level_nxt;
    end

    assign level = level_reg;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed bench for fifo_ctrl with a local storage model; FIFO_CTRL_LEVEL_EN adds level checks
module tb_fifo_ctrl;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr, rd;
    logic          wr_en;
    logic [AW-1:0] w_addr, r_addr;
    logic          full, empty, overflow, underflow;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [AW:0]   level;
`endif

    logic [7:0] din;
    logic [7:0] mem [4];
    logic [7:0] head;

    int total = 0;
    int passed = 0;
    int failed = 0;

    fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd        (rd),
        .wr_en     (wr_en),
        .w_addr    (w_addr),
        .r_addr    (r_addr),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef FIFO_CTRL_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) mem[w_addr] <= din;
    assign head = mem[r_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
        #12;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_waddr", 32'(w_addr), 32'd0);
        check("rst_raddr", 32'(r_addr), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        check("rst_wren0", 32'(wr_en), 32'd0);
        wr = 1'b1; #1;
        check("rst_wren1", 32'(wr_en), 32'd1);
`ifdef FIFO_CTRL_LEVEL_EN
        check("rst_level", 32'(level), 32'd0);
`endif
        wr = 1'b0;
        @(negedge clk); reset = 1'b0;
        tick(); tick();
        check("idle_empty", 32'(empty), 32'd1);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1; din = 8'hA0 + 8'(i); #1;
            check("fill_wren", 32'(wr_en), 32'd1);
            tick();
            check("fill_empty", 32'(empty), 32'd0);
            check("fill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
            check("fill_waddr", 32'(w_addr), 32'((i + 1) % 4));
        end
`ifdef FIFO_CTRL_LEVEL_EN
        check("fill_level", 32'(level), 32'd4);
`endif
        din = 8'hEE; #1;
        check("ovf_wren", 32'(wr_en), 32'd0);
        tick();
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_waddr", 32'(w_addr), 32'd0);
        wr = 1'b0;
        tick();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 32'(head), 32'(8'hA0 + 8'(i)));
            rd = 1'b1;
            tick();
            check("drain_raddr", 32'(r_addr), 32'((i + 1) % 4));
            check("drain_empty", 32'(empty), (i == 3) ? 32'd1 : 32'd0);
            check("drain_full", 32'(full), 32'd0);
        end
        tick();
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_empty", 32'(empty), 32'd1);
        rd = 1'b0;
        tick();
        check("unf_clear", 32'(underflow), 32'd0);

        // Simultaneous wr/rd while empty
        wr = 1'b1; rd = 1'b1; din = 8'hB0; #1;
        check("rwe_wren", 32'(wr_en), 32'd1);
        tick();
        check("rwe_empty", 32'(empty), 32'd0);
        check("rwe_unf", 32'(underflow), 32'd0);
        check("rwe_waddr", 32'(w_addr), 32'd1);
        check("rwe_raddr", 32'(r_addr), 32'd0);
        check("rwe_head", 32'(head), 32'hB0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("rwe_level", 32'(level), 32'd1);
`endif
        rd = 1'b0;
        for (int i = 1; i < 4; i++) begin
            din = 8'hB0 + 8'(i);
            tick();
        end
        wr = 1'b0;
        check("rwf_pre_full", 32'(full), 32'd1);
        check("rwf_pre_waddr", 32'(w_addr), 32'd0);

        // Simultaneous wr/rd while full
        wr = 1'b1; rd = 1'b1; din = 8'hC0; #1;
        check("rwf_wren", 32'(wr_en), 32'd1);
        check("rwf_oldhead", 32'(head), 32'hB0);
        tick();
        check("rwf_full", 32'(full), 32'd1);
        check("rwf_waddr", 32'(w_addr), 32'd1);
        check("rwf_raddr", 32'(r_addr), 32'd1);
        check("rwf_head", 32'(head), 32'hB1);
        check("rwf_ovf", 32'(overflow), 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("rwf_level", 32'(level), 32'd4);
`endif
        wr = 1'b0; rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rwf_drain", 32'(head), (i == 3) ? 32'hC0 : 32'(8'hB1 + 8'(i)));
            tick();
        end
        rd = 1'b0;
        check("rwf_empty", 32'(empty), 32'd1);
        check("rwf_end_raddr", 32'(r_addr), 32'd1);

        // Interleaved traffic across the pointer wrap
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; din = 8'hD0 + 8'(i);
            tick();
            wr = 1'b0;
            check("wrap_waddr", 32'(w_addr), 32'((2 + i) % 4));
            check("wrap_head", 32'(head), 32'(8'hD0 + 8'(i)));
            rd = 1'b1;
            tick();
            rd = 1'b0;
            check("wrap_raddr", 32'(r_addr), 32'((2 + i) % 4));
            check("wrap_empty", 32'(empty), 32'd1);
        end

        // Asynchronous reset with three words held
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hE0 + 8'(i);
            tick();
        end
        wr = 1'b0;
        check("ar_pre_waddr", 32'(w_addr), 32'd2);
        check("ar_pre_empty", 32'(empty), 32'd0);
        #1; reset = 1'b1; #1;
        check("ar_empty", 32'(empty), 32'd1);
        check("ar_full", 32'(full), 32'd0);
        check("ar_waddr", 32'(w_addr), 32'd0);
        check("ar_raddr", 32'(r_addr), 32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("ar_level", 32'(level), 32'd0);
`endif
        @(negedge clk); reset = 1'b0;
        wr = 1'b1; din = 8'hF5;
        tick();
        wr = 1'b0;
        check("post_head", 32'(head), 32'hF5);
        check("post_waddr", 32'(w_addr), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
